// File: rtl/framebuf_wr_arb.sv
// Frame-buffer write arbiter: camera and host write requests share one RAM
// write port with round-robin arbitration. An optional clear engine sweeps
// CLEAR_COLOR over locations 0..NPIX-1, one location per cycle.
// Optional feature macro: FRAMEBUF_WR_ARB_CLEAR_EN. When it is undefined,
// clear_start is ignored and clear_busy/clear_done are tied low.
module framebuf_wr_arb #(
  parameter int             AW          = 17,
  parameter int             DW          = 16,
  parameter int             NPIX        = 19200,
  parameter logic [DW-1:0]  CLEAR_COLOR = {DW{1'b0}}
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cam_valid,
  input  logic [AW-1:0] cam_addr,
  input  logic [DW-1:0] cam_data,
  output logic          cam_ready,
  input  logic          host_valid,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_data,
  output logic          host_ready,
  input  logic          clear_start,
  output logic          clear_busy,
  output logic          clear_done,
  output logic [AW-1:0] addr_in,
  output logic [DW-1:0] data_in,
  output logic          regwrite
);

  logic          in_arb;      // FSM is arbitrating requesters
  logic          clear_go;    // clear accepted this cycle, requesters held off
  logic          clear_wr;    // sweep write issued this cycle
  logic [AW-1:0] clear_addr;  // sweep location for this cycle

  logic          rr_host_q;   // 1: host wins the next tie, 0: camera wins
  logic          regwrite_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] data_q;

`ifdef FRAMEBUF_WR_ARB_CLEAR_EN
  typedef enum logic {ST_ARB = 1'b0, ST_CLEAR = 1'b1} state_t;

  localparam logic [AW-1:0] LAST = AW'(NPIX - 1);

  state_t        state_q;
  logic [AW-1:0] cnt_q;
  logic [AW-1:0] cnt_d;
  logic          clear_done_q;

  assign in_arb     = (state_q == ST_ARB);
  assign clear_go   = in_arb & clear_start;
  assign clear_wr   = (state_q == ST_CLEAR);
  assign clear_addr = cnt_q;
  assign cnt_d      = cnt_q + AW'(1);
  assign clear_busy = clear_wr;
  assign clear_done = clear_done_q;

  // Sweep FSM: enter CLEAR on clear_start, leave after location NPIX-1, pulse done on return
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_ARB;
      cnt_q        <= '0;
      clear_done_q <= 1'b0;
    end else begin
      clear_done_q <= 1'b0;
      case (state_q)
        ST_ARB: begin
          if (clear_start) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
          end
        end
        ST_CLEAR: begin
          if (cnt_q == LAST) begin
            state_q      <= ST_ARB;
            cnt_q        <= '0;
            clear_done_q <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: state_q <= ST_ARB;
      endcase
    end
  end
`else
  logic unused_clear;

  assign unused_clear = clear_start ^ NPIX[0];
  assign in_arb       = 1'b1;
  assign clear_go     = 1'b0;
  assign clear_wr     = 1'b0;
  assign clear_addr   = '0;
  assign clear_busy   = 1'b0;
  assign clear_done   = 1'b0;
`endif

  // Combinational grant: a lone requester wins, a tie goes to whoever was not granted last
  always_comb begin
    cam_ready  = 1'b0;
    host_ready = 1'b0;
    if (in_arb && !clear_go) begin
      cam_ready  = cam_valid  & (~host_valid | ~rr_host_q);
      host_ready = host_valid & (~cam_valid  |  rr_host_q);
    end
  end

  // Registered write port: sweep writes take precedence, then the accepted requester
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regwrite_q <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      rr_host_q  <= 1'b0;
    end else if (clear_wr) begin
      regwrite_q <= 1'b1;
      addr_q     <= clear_addr;
      data_q     <= CLEAR_COLOR;
    end else if (cam_ready) begin
      regwrite_q <= 1'b1;
      addr_q     <= cam_addr;
      data_q     <= cam_data;
      rr_host_q  <= 1'b1;
    end else if (host_ready) begin
      regwrite_q <= 1'b1;
      addr_q     <= host_addr;
      data_q     <= host_data;
      rr_host_q  <= 1'b0;
    end else begin
      regwrite_q <= 1'b0;
    end
  end

  assign regwrite = regwrite_q;
  assign addr_in  = addr_q;
  assign data_in  = data_q;

endmodule
